opl3_host_if: RTL and testbench

- Host-bus front end that sits directly upstream of the OPL3 synthesis core and produces its `opl_reg[512]` register image.
- Decodes the OPL3 four-port bus: bank-0 address, data, bank-1 address, data.
- Implements timer 1 (80 µs tick) and timer 2 (320 µs tick), the status register and the IRQ output.
- Emulates chip write-busy timing so host software sees realistic wait states.

---
 rtl/opl3_host_if_pkg.sv | 44 ++++
 rtl/opl3_timer.sv | 41 ++++
 rtl/opl3_host_if.sv | 180 ++++++++++++++++++
 tb/tb_opl3_host_if.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opl3_host_if_pkg.sv
// Shared constants for the OPL3 host-bus front end: port map, register
// addresses, status/control bit positions and the timer width.
package opl3_host_if_pkg;

   // 80 us timer-1 tick at a 14.318 MHz system clock
   localparam int OPL_TIMER1_DIV  = 1145;

   // Width of a timer counter / preset register
   localparam int REG_TIMER_WIDTH = 8;

   // Host bus port encodings
   localparam logic [1:0] PORT_ADDR0 = 2'd0;
   localparam logic [1:0] PORT_DATA0 = 2'd1;
   localparam logic [1:0] PORT_ADDR1 = 2'd2;
   localparam logic [1:0] PORT_DATA1 = 2'd3;

   // Status register bit positions
   localparam int STAT_IRQ = 7;
   localparam int STAT_FT1 = 6;
   localparam int STAT_FT2 = 5;

   // Timer control register (0x004) bit positions
   localparam int CTRL_IRQ_RST = 7;
   localparam int CTRL_MASK1   = 6;
   localparam int CTRL_MASK2   = 5;
   localparam int CTRL_ST2     = 1;
   localparam int CTRL_ST1     = 0;

   // Register image indices, {bank, reg[7:0]}
   localparam logic [8:0] REG_TIMER1     = 9'h002;
   localparam logic [8:0] REG_TIMER2     = 9'h003;
   localparam logic [8:0] REG_TIMER_CTRL = 9'h004;

   // Even ports latch the register index
   function automatic logic is_addr_port(input logic [1:0] port);
      return (port == PORT_ADDR0) || (port == PORT_ADDR1);
   endfunction

   // Odd ports write the latched register
   function automatic logic is_data_port(input logic [1:0] port);
      return (port == PORT_DATA0) || (port == PORT_DATA1);
   endfunction

endpackage

// File: rtl/opl3_timer.sv
// One OPL3 interval timer: an up-counter that reloads from its preset when
// started and on every overflow. Flag and mask handling live in the parent.
module opl3_timer
   import opl3_host_if_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       tick,
   input  logic                       start,
   input  logic [REG_TIMER_WIDTH-1:0] preset,
   output logic                       overflow
);

   logic [REG_TIMER_WIDTH-1:0] cnt_reg;
   logic                       start_reg;
   logic                       start_rise;

   // A fresh start always reloads; a tick landing on that same cycle is lost.
   assign start_rise = start & ~start_reg;
   assign overflow   = start & ~start_rise & tick & (cnt_reg == '1);

   // Counter: load on start edge, count ticks while running, hold when stopped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg   <= '0;
         start_reg <= 1'b0;
      end else begin
         start_reg <= start;
         if (start_rise) begin
            cnt_reg <= preset;
         end else if (start && tick) begin
            if (overflow) begin
               cnt_reg <= preset;
            end else begin
               cnt_reg <= cnt_reg + REG_TIMER_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: rtl/opl3_host_if.sv
// OPL3 host-bus front end: four-port register access, the 512-entry register
// image seen by the synthesis core, timers 1/2 with status/IRQ, and emulated
// write-busy wait states.
module opl3_host_if
   import opl3_host_if_pkg::*;
#(
   parameter int TIMER1_DIV = OPL_TIMER1_DIV,
   parameter int ADDR_WAIT  = 12,
   parameter int DATA_WAIT  = 84
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cs,
   input  logic       we,
   input  logic [1:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       busy,
   output logic       irq_n,
   output logic [7:0] opl_reg [512]
);

   localparam int PRE_W    = (TIMER1_DIV < 2) ? 1 : $clog2(TIMER1_DIV);
   localparam int WAIT_MAX = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
   localparam int BUSY_W   = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
   localparam logic [BUSY_W-1:0] ADDR_LOAD = BUSY_W'((ADDR_WAIT > 0) ? ADDR_WAIT - 1 : 0);
   localparam logic [BUSY_W-1:0] DATA_LOAD = BUSY_W'((DATA_WAIT > 0) ? DATA_WAIT - 1 : 0);

   logic [8:0]        index_reg;
   logic              busy_reg;
   logic [BUSY_W-1:0] busy_cnt_reg;
   logic [PRE_W-1:0]  pre_reg;
   logic [1:0]        t2div_reg;
   logic              ft1_reg, ft2_reg;
   logic              ft1_next, ft2_next;
   logic              irq_n_reg;

   logic wr_ok, addr_wr, data_wr, irq_rst, reg_we;
   logic tick1, tick2;
   logic mask1, mask2;
   logic [7:0] status_vec;

   logic [1:0]                 tick_vec, start_vec, ovf_vec;
   logic [REG_TIMER_WIDTH-1:0] preset_arr [2];

   // Bus decode: writes while busy are dropped, reads never are
   assign wr_ok   = cs & we & ~busy_reg;
   assign addr_wr = wr_ok & is_addr_port(addr);
   assign data_wr = wr_ok & is_data_port(addr);

   // A control write with bit 7 set only clears the flags; nothing is stored
   assign irq_rst = data_wr & (index_reg == REG_TIMER_CTRL) & din[CTRL_IRQ_RST];
   assign reg_we  = data_wr & ~irq_rst;

   assign mask1 = opl_reg[REG_TIMER_CTRL][CTRL_MASK1];
   assign mask2 = opl_reg[REG_TIMER_CTRL][CTRL_MASK2];

   assign busy  = busy_reg;
   assign irq_n = irq_n_reg;

   // Register image write port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 512; i++) begin
            opl_reg[i] <= '0;
         end
      end else if (reg_we) begin
         opl_reg[index_reg] <= din;
      end
   end

   // Index latch: bank comes from the port, register number from the data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         index_reg <= '0;
      end else if (addr_wr) begin
         index_reg <= {addr[1], din};
      end
   end

   // Busy window: load WAIT-1 on accept and stay busy through the zero count,
   // so busy is high for exactly WAIT cycles; WAIT = 0 never asserts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_reg     <= 1'b0;
         busy_cnt_reg <= '0;
      end else if (addr_wr && ADDR_WAIT > 0) begin
         busy_reg     <= 1'b1;
         busy_cnt_reg <= ADDR_LOAD;
      end else if (data_wr && DATA_WAIT > 0) begin
         busy_reg     <= 1'b1;
         busy_cnt_reg <= DATA_LOAD;
      end else if (busy_reg) begin
         if (busy_cnt_reg == '0) begin
            busy_reg <= 1'b0;
         end else begin
            busy_cnt_reg <= busy_cnt_reg - BUSY_W'(1);
         end
      end
   end

   // Free-running prescaler: tick1 every TIMER1_DIV cycles, tick2 every 4th tick1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_reg   <= '0;
         t2div_reg <= '0;
      end else if (tick1) begin
         pre_reg   <= '0;
         t2div_reg <= t2div_reg + 2'd1;
      end else begin
         pre_reg   <= pre_reg + PRE_W'(1);
      end
   end

   assign tick1 = (pre_reg == PRE_W'(TIMER1_DIV - 1));
   assign tick2 = tick1 & (t2div_reg == 2'd3);

   assign tick_vec      = {tick2, tick1};
   assign start_vec     = {opl_reg[REG_TIMER_CTRL][CTRL_ST2], opl_reg[REG_TIMER_CTRL][CTRL_ST1]};
   assign preset_arr[0] = opl_reg[REG_TIMER1];
   assign preset_arr[1] = opl_reg[REG_TIMER2];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_timer
         opl3_timer u_timer (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick     (tick_vec[gi]),
            .start    (start_vec[gi]),
            .preset   (preset_arr[gi]),
            .overflow (ovf_vec[gi])
         );
      end
   endgenerate

   // Flag update: IRQ-reset beats a same-cycle overflow; masking only blocks setting
   always_comb begin
      ft1_next = ft1_reg;
      ft2_next = ft2_reg;
      if (irq_rst) begin
         ft1_next = 1'b0;
         ft2_next = 1'b0;
      end else begin
         if (ovf_vec[0] && !mask1) ft1_next = 1'b1;
         if (ovf_vec[1] && !mask2) ft2_next = 1'b1;
      end
   end

   // Flag and IRQ registers; irq_n follows the flags one cycle later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ft1_reg   <= 1'b0;
         ft2_reg   <= 1'b0;
         irq_n_reg <= 1'b1;
      end else begin
         ft1_reg   <= ft1_next;
         ft2_reg   <= ft2_next;
         irq_n_reg <= ~(ft1_reg | ft2_reg);
      end
   end

   // Status byte as seen on a port-0 read
   always_comb begin
      status_vec           = '0;
      status_vec[STAT_IRQ] = ft1_reg | ft2_reg;
      status_vec[STAT_FT1] = ft1_reg;
      status_vec[STAT_FT2] = ft2_reg;
   end

   // Read data: registered, one cycle latency, does not touch the flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout <= '0;
      end else if (cs && !we) begin
         dout <= (addr == PORT_ADDR0) ? status_vec : 8'hFF;
      end
   end

endmodule

// File: tb/tb_opl3_host_if.sv
// Directed bench for opl3_host_if. Reads are checked by a scoreboard queue
// popped by a monitor when read data becomes valid; other observations are
// compared inline against hand-computed values.
`timescale 1ns/1ps
module tb_opl3_host_if;

   localparam int DIV = 1145;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       cs    = 1'b0;
   logic       we    = 1'b0;
   logic [1:0] addr  = 2'd0;
   logic [7:0] din   = 8'h00;
   logic [7:0] dout;
   logic       busy;
   logic       irq_n;
   logic [7:0] opl_reg [512];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      string      name;
      logic [7:0] exp;
   } rd_exp_t;

   rd_exp_t rd_q [$];
   rd_exp_t mon_e;
   logic    rd_pend = 1'b0;

   opl3_host_if #(
      .TIMER1_DIV (DIV),
      .ADDR_WAIT  (12),
      .DATA_WAIT  (84)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .cs      (cs),
      .we      (we),
      .addr    (addr),
      .din     (din),
      .dout    (dout),
      .busy    (busy),
      .irq_n   (irq_n),
      .opl_reg (opl_reg)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // A read sampled at a rising edge has its data on dout after that edge
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_pend <= 1'b0;
      else        rd_pend <= cs & ~we;
   end

   // Monitor: pop the expected read value whenever read data is presented
   always @(negedge clk) begin
      if (rd_pend) begin
         checks++;
         if (rd_q.size() == 0) begin
            errors++;
            $display("FAIL read_unexpected: dout=0x%02h, no expected entry queued", dout);
         end else begin
            mon_e = rd_q.pop_front();
            if (dout !== mon_e.exp) begin
               errors++;
               $display("FAIL %s: dout=0x%02h, expected 0x%02h", mon_e.name, dout, mon_e.exp);
            end else begin
               $display("RD  %s: dout=0x%02h", mon_e.name, dout);
            end
         end
      end
   end

   initial begin
      #(600000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         $display("CHK %s: 0x%0h", name, act);
      end
   endtask

   task automatic wait_not_busy();
      int n = 0;
      while (busy !== 1'b0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         checks++;
         errors++;
         $display("FAIL busy_timeout: busy=%b after %0d cycles, expected 0", busy, n);
      end
   endtask

   task automatic drive_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; we = 1'b1; addr = a; din = d;
      @(negedge clk);
      cs = 1'b0; we = 1'b0;
      $display("WR  port=%0d din=0x%02h", a, d);
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      wait_not_busy();
      drive_write(a, d);
   endtask

   task automatic bus_read(input logic [1:0] a, input logic [7:0] e, input string nm);
      @(negedge clk);
      cs = 1'b1; we = 1'b0; addr = a;
      rd_q.push_back('{name: nm, exp: e});
      @(negedge clk);
      cs = 1'b0;
   endtask

   task automatic measure_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic wait_irq(input logic lvl, input int bound, input string nm, output int at_cyc);
      int n = 0;
      while (irq_n !== lvl && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (irq_n !== lvl) begin
         checks++;
         errors++;
         at_cyc = -1;
         $display("FAIL %s: irq_n=%b after %0d cycles, expected %b", nm, irq_n, n, lvl);
      end else begin
         at_cyc = cyc;
         $display("EVT %s: irq_n=%b at cycle %0d", nm, irq_n, cyc);
      end
   endtask

   task automatic count_irq_low(input int cycles, output int lows);
      lows = 0;
      repeat (cycles) begin
         if (irq_n !== 1'b1) lows++;
         @(negedge clk);
      end
   endtask

   function automatic int count_nonzero(input int skip_a, input int skip_b);
      int n = 0;
      for (int i = 0; i < 512; i++) begin
         if (i != skip_a && i != skip_b && opl_reg[i] !== 8'h00) n++;
      end
      return n;
   endfunction

   initial begin
      int n;
      int t0;
      int c1;
      int c2;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_irq_n", irq_n, 1);
      check("reset_dout", dout, 8'h00);
      check("reset_regs_zero", count_nonzero(-1, -1), 0);
      rst_n = 1'b1;

      bus_read(2'd0, 8'h00, "status_after_reset");
      bus_read(2'd2, 8'hFF, "read_port2");

      // Bank-0 write, busy window lengths, no auto-increment
      bus_write(2'd0, 8'h20);
      measure_busy(n);
      check("addr_busy_len", n, 12);
      bus_write(2'd1, 8'h21);
      measure_busy(n);
      check("data_busy_len", n, 84);
      check("reg_020", opl_reg[9'h020], 8'h21);
      check("others_zero", count_nonzero(9'h020, 9'h020), 0);
      bus_write(2'd1, 8'h22);
      wait_not_busy();
      check("reg_020_no_autoinc", opl_reg[9'h020], 8'h22);
      check("reg_021_untouched", opl_reg[9'h021], 8'h00);

      // Bank-1 write, then a dropped write during busy
      bus_write(2'd2, 8'h05);
      bus_write(2'd1, 8'h01);
      drive_write(2'd3, 8'h77);
      wait_not_busy();
      check("reg_105", opl_reg[9'h105], 8'h01);
      check("reg_005_unchanged", opl_reg[9'h005], 8'h00);
      check("others_zero_2", count_nonzero(9'h020, 9'h105), 0);
      bus_read(2'd1, 8'hFF, "read_port1");
      bus_read(2'd3, 8'hFF, "read_port3");

      // Timer 1, preset 0xFE: two ticks to overflow, period 2*DIV
      bus_write(2'd0, 8'h02);
      bus_write(2'd1, 8'hFE);
      bus_write(2'd0, 8'h04);
      bus_write(2'd1, 8'h01);
      t0 = cyc;
      wait_irq(1'b0, 2400, "t1_first_irq", c1);
      check("t1_first_window", (c1 - t0 >= DIV + 3) && (c1 - t0 <= 2 * DIV + 2), 1);
      bus_read(2'd0, 8'hC0, "status_ft1");
      bus_write(2'd1, 8'h80);
      wait_irq(1'b1, 10, "t1_irq_cleared", n);
      check("ctrl_kept_after_clear", opl_reg[9'h004], 8'h01);
      bus_read(2'd0, 8'h00, "status_t1_cleared");
      wait_irq(1'b0, 2400, "t1_second_irq", c2);
      check("t1_period", c2 - c1, 2 * DIV);
      bus_read(2'd0, 8'hC0, "status_ft1_again");
      bus_write(2'd1, 8'h00);
      bus_write(2'd1, 8'h80);
      wait_irq(1'b1, 10, "t1_stopped_cleared", n);

      // Timer 2, preset 0xFF: overflow on every tick2, period 4*DIV, then masked
      bus_write(2'd0, 8'h03);
      bus_write(2'd1, 8'hFF);
      bus_write(2'd0, 8'h04);
      bus_write(2'd1, 8'h02);
      t0 = cyc;
      wait_irq(1'b0, 4700, "t2_first_irq", c1);
      check("t2_first_window", (c1 - t0 >= 3) && (c1 - t0 <= 4 * DIV + 2), 1);
      bus_read(2'd0, 8'hA0, "status_ft2");
      bus_write(2'd1, 8'h80);
      wait_irq(1'b1, 10, "t2_irq_cleared", n);
      wait_irq(1'b0, 4700, "t2_second_irq", c2);
      check("t2_period", c2 - c1, 4 * DIV);
      bus_write(2'd1, 8'h80);
      bus_write(2'd1, 8'h22);
      count_irq_low(4700, n);
      check("t2_masked_no_irq", n, 0);
      bus_read(2'd0, 8'h00, "status_t2_masked");
      bus_write(2'd1, 8'h00);

      // IRQ reset in the same cycle as a timer-1 overflow
      bus_write(2'd0, 8'h02);
      bus_write(2'd1, 8'hFF);
      bus_write(2'd0, 8'h04);
      bus_write(2'd1, 8'h01);
      wait_irq(1'b0, 1200, "t1ff_first_irq", c1);
      bus_write(2'd1, 8'h80);
      wait_irq(1'b1, 10, "t1ff_cleared", n);
      wait_not_busy();
      while (cyc < c1 + DIV - 3) @(negedge clk);
      drive_write(2'd1, 8'h80);
      count_irq_low(4, n);
      check("coincident_irq_stays_high", n, 0);
      bus_read(2'd0, 8'h00, "status_coincident");
      check("ctrl_kept_coincident", opl_reg[9'h004], 8'h01);
      wait_irq(1'b0, 1200, "t1ff_next_irq", c2);
      check("t1ff_two_periods", c2 - c1, 2 * DIV);

      // Reset mid-busy with a flag set and timer 1 running
      bus_read(2'd1, 8'hFF, "read_before_reset");
      bus_write(2'd0, 8'h10);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_busy", busy, 0);
      check("midreset_irq_n", irq_n, 1);
      check("midreset_dout", dout, 8'h00);
      check("midreset_regs_zero", count_nonzero(-1, -1), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      count_irq_low(3000, n);
      check("timers_stopped_after_reset", n, 0);
      check("busy_after_release", busy, 0);
      bus_read(2'd0, 8'h00, "status_after_midreset");

      // Timers run again once restarted
      bus_write(2'd0, 8'h02);
      bus_write(2'd1, 8'hFF);
      bus_write(2'd0, 8'h04);
      bus_write(2'd1, 8'h01);
      wait_irq(1'b0, 1200, "restart_irq", c1);
      bus_read(2'd0, 8'hC0, "status_restart");

      @(negedge clk);
      check("scoreboard_drained", rd_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
